// File: rtl/instr_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package instr_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer; optional immediate range/alignment
// checking is compiled in with the IMM_CHECK_EN macro.
module instr_pack
    import instr_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_instr,
    output logic        o_err
);

    fmt_t w_fmt;
    logic w_fmt_err;

    assign w_fmt = fmt_t'(i_fmt);

    always_comb begin
        o_instr   = NOP_INSTR;
        w_fmt_err = 1'b0;
        case (w_fmt)
            FMT_R: o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            FMT_I: o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            FMT_S: o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            FMT_B: o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                              i_imm[4:1], i_imm[11], i_opcode};
            FMT_U: o_instr = {i_imm[31:12], i_rd, i_opcode};
            FMT_J: o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                              i_rd, i_opcode};
            default: begin
                o_instr   = NOP_INSTR;
                w_fmt_err = 1'b1;
            end
        endcase
    end

`ifdef IMM_CHECK_EN
    logic signed [31:0] w_imm;
    logic               w_imm_err;

    assign w_imm = i_imm;

    // Out-of-range words are still packed (truncated); only the flag is raised.
    always_comb begin
        w_imm_err = 1'b0;
        case (w_fmt)
            FMT_I, FMT_S: w_imm_err = (w_imm < -32'sd2048) || (w_imm > 32'sd2047);
            FMT_B:        w_imm_err = (w_imm < -32'sd4096) || (w_imm > 32'sd4094) || w_imm[0];
            FMT_J:        w_imm_err = (w_imm < -32'sd1048576) || (w_imm > 32'sd1048574)
                                      || w_imm[0];
            FMT_U:        w_imm_err = (w_imm[11:0] != 12'd0);
            default:      w_imm_err = 1'b0;
        endcase
    end

    assign o_err = w_fmt_err || w_imm_err;
`else
    assign o_err = w_fmt_err;
`endif

endmodule

// File: rtl/instr_encode.sv
// RV32I encoder top: output register, program FSM, address and word counters.
// Optional immediate checking in instr_pack is enabled with IMM_CHECK_EN.
module instr_encode
    import instr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_addr,
    output logic             out_err,
    output logic             done,
    output logic [CNT_W-1:0] word_cnt,
    output logic             err_sticky
);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_valid;
    logic [31:0]       r_instr;
    logic [31:0]       r_addr;
    logic              r_err;
    logic              r_last;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sticky;

    logic              w_in_xfer;
    logic              w_out_xfer;
    logic [31:0]       w_instr;
    logic              w_err;
    logic [31:0]       w_addr_base;
    logic [CNT_W-1:0]  w_cnt_base;
    logic              w_sticky_base;

    instr_pack u_pack (
        .i_fmt    (in_fmt),
        .i_opcode (in_opcode),
        .i_rd     (in_rd),
        .i_rs1    (in_rs1),
        .i_rs2    (in_rs2),
        .i_funct3 (in_funct3),
        .i_funct7 (in_funct7),
        .i_imm    (in_imm),
        .o_instr  (w_instr),
        .o_err    (w_err)
    );

    assign in_ready   = !r_valid || out_ready;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_valid && out_ready;

    // A word may already belong to the next program while in DONE, so DONE
    // goes straight back to RUN when one is held or arriving.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_in_xfer) w_state_next = ST_RUN;
            ST_RUN:  if (w_out_xfer && r_last) w_state_next = ST_DONE;
            ST_DONE: begin
                if (w_out_xfer && r_last)      w_state_next = ST_DONE;
                else if (r_valid || w_in_xfer) w_state_next = ST_RUN;
                else                           w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_addr_base   = (r_state == ST_DONE) ? BASE_ADDR : r_addr;
    assign w_cnt_base    = (r_state == ST_DONE) ? '0 : r_cnt;
    assign w_sticky_base = (r_state == ST_DONE) ? (r_valid && r_err) : r_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_valid  <= 1'b0;
            r_instr  <= '0;
            r_addr   <= BASE_ADDR;
            r_err    <= 1'b0;
            r_last   <= 1'b0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_in_xfer) begin
                r_valid <= 1'b1;
                r_instr <= w_instr;
                r_err   <= w_err;
                r_last  <= in_last;
            end else if (w_out_xfer) begin
                r_valid <= 1'b0;
            end
            // After a last word the next load starts the new program at BASE_ADDR.
            if (w_out_xfer) begin
                r_addr <= r_last ? BASE_ADDR : w_addr_base + 32'd4;
                r_cnt  <= (w_cnt_base == {CNT_W{1'b1}}) ? w_cnt_base : w_cnt_base + CNT_W'(1);
            end else begin
                r_addr <= w_addr_base;
                r_cnt  <= w_cnt_base;
            end
            r_sticky <= w_sticky_base || (w_in_xfer && w_err);
        end
    end

    assign out_valid  = r_valid;
    assign out_instr  = r_instr;
    assign out_addr   = r_addr;
    assign out_err    = r_err;
    assign done       = (r_state == ST_DONE);
    assign word_cnt   = r_cnt;
    assign err_sticky = r_sticky;

endmodule

// File: tb/tb_instr_encode.sv
// Directed, table-driven bench for instr_encode (honours IMM_CHECK_EN).
module tb_instr_encode;

`ifdef IMM_CHECK_EN
    localparam logic IMMCHK = 1'b1;
`else
    localparam logic IMMCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic        done;
    logic [15:0] word_cnt;
    logic        err_sticky;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        last;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    vec_t tbl [10];

    instr_encode #(.BASE_ADDR(32'h0000_0000), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fmt     (in_fmt),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .out_err    (out_err),
        .done       (done),
        .word_cnt   (word_cnt),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid  = 1'b1;
        in_fmt    = v.fmt;
        in_opcode = v.op;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_imm    = v.imm;
        in_last   = v.last;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        //              fmt  op     rd  rs1 rs2 f3 f7     imm            last exp_instr      err
        tbl[0] = '{3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1000, 1'b0, 32'h0000_10B7, 1'b0};
        tbl[1] = '{3'd0, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'h0000_0000, 1'b0, 32'h0010_80B3, 1'b0};
        tbl[2] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd16,        1'b0, 32'h0100_00EF, 1'b0};
        tbl[3] = '{3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd1, 7'h00, 32'h0000_0005, 1'b0, 32'h0051_9113, 1'b0};
        tbl[4] = '{3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 7'h00, 32'h0000_0403, 1'b0, 32'h4030_D093, 1'b0};
        tbl[5] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 1'b0, 32'hFFF0_0093, 1'b0};
        tbl[6] = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFF_FFFC, 1'b0, 32'hFE20_AE23, 1'b0};
        tbl[7] = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd1, 3'd0, 7'h00, 32'hFFFF_FFF8, 1'b0, 32'hFE10_8CE3, 1'b0};
        tbl[8] = '{3'd6, 7'h33, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 32'h1234_5678, 1'b0, 32'h0000_0013, 1'b1};
        tbl[9] = '{3'd7, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0000, 1'b1, 32'h0000_0013, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0; in_last = 1'b0;
        step; step;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", out_addr, 32'h0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        // Program 1: back-to-back table, one word per cycle.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i]);
            step;
            chk($sformatf("t%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("t%0d_instr", i), out_instr, tbl[i].exp_instr);
            chk($sformatf("t%0d_err", i), 32'(out_err), 32'(tbl[i].exp_err));
            chk($sformatf("t%0d_addr", i), out_addr, 32'(i * 4));
            chk($sformatf("t%0d_cnt", i), 32'(word_cnt), 32'(i));
            chk($sformatf("t%0d_sticky", i), 32'(err_sticky), 32'(i >= 8));
        end
        in_valid = 1'b0;
        step;
        chk("p1_done", 32'(done), 32'd1);
        chk("p1_valid", 32'(out_valid), 32'd0);
        chk("p1_cnt", 32'(word_cnt), 32'd10);
        chk("p1_sticky", 32'(err_sticky), 32'd1);
        step;
        chk("p1_done_end", 32'(done), 32'd0);
        chk("p1_cnt_clr", 32'(word_cnt), 32'd0);
        chk("p1_sticky_clr", 32'(err_sticky), 32'd0);
        chk("p1_addr_rld", out_addr, 32'h0);

        // Program 2: single branch word tagged last.
        v = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd1, 3'd0, 7'h00, 32'd8, 1'b1, 32'h0010_8463, 1'b0};
        drive(v);
        step;
        in_valid = 1'b0;
        chk("b_instr", out_instr, v.exp_instr);
        chk("b_addr", out_addr, 32'h0);
        chk("b_done_early", 32'(done), 32'd0);
        step;
        chk("b_done", 32'(done), 32'd1);
        chk("b_cnt1", 32'(word_cnt), 32'd1);
        step;
        chk("b_done_pulse", 32'(done), 32'd0);
        chk("b_cnt0", 32'(word_cnt), 32'd0);

        // Program 3: addi at BASE_ADDR, then a 3-cycle output stall with 2 words offered.
        v = '{3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'h00, 32'd2, 1'b0, 32'h0020_8093, 1'b0};
        drive(v);
        step;
        chk("i_instr", out_instr, 32'h0020_8093);
        chk("i_addr", out_addr, 32'h0);
        chk("i_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        v = '{3'd0, 7'h33, 5'd2, 5'd3, 5'd4, 3'd0, 7'h20, 32'h0, 1'b0, 32'h4041_8133, 1'b0};
        drive(v);
        for (int c = 0; c < 3; c++) begin
            step;
            chk($sformatf("stall%0d_ready", c), 32'(in_ready), 32'd0);
            chk($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_instr", c), out_instr, 32'h0020_8093);
            chk($sformatf("stall%0d_addr", c), out_addr, 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("stall_release_ready", 32'(in_ready), 32'd1);
        step;
        chk("w1_instr", out_instr, 32'h4041_8133);
        chk("w1_addr", out_addr, 32'h4);
        chk("w1_cnt", 32'(word_cnt), 32'd1);
        v = '{3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'hABCD_E000, 1'b1, 32'hABCD_E1B7, 1'b0};
        drive(v);
        step;
        in_valid = 1'b0;
        chk("w2_instr", out_instr, 32'hABCD_E1B7);
        chk("w2_addr", out_addr, 32'h8);
        chk("w2_cnt", 32'(word_cnt), 32'd2);
        step;
        chk("p3_done", 32'(done), 32'd1);
        chk("p3_cnt", 32'(word_cnt), 32'd3);
        step;

        // Program 4: immediates outside the encodable range, then reset mid-program.
        v = '{3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048, 1'b0, 32'h8000_0013, IMMCHK};
        drive(v);
        step;
        chk("imm_i_instr", out_instr, v.exp_instr);
        chk("imm_i_err", 32'(out_err), 32'(IMMCHK));
        v = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3, 1'b0, 32'h0000_0163, IMMCHK};
        drive(v);
        step;
        chk("imm_b_instr", out_instr, v.exp_instr);
        chk("imm_b_err", 32'(out_err), 32'(IMMCHK));
        chk("imm_b_addr", out_addr, 32'h4);
        in_valid = 1'b0;
        out_ready = 1'b0;
        step;
        chk("hold_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_instr", out_instr, 32'h0);
        chk("mrst_addr", out_addr, 32'h0);
        chk("mrst_err", 32'(out_err), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_cnt", 32'(word_cnt), 32'd0);
        chk("mrst_sticky", 32'(err_sticky), 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step;
            chk($sformatf("mrst_gone%0d", c), 32'(out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_encode.md
INSTR_ENCODE -- requirements
Module: instr_encode

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the address assigned to the first word of each program.
REQ-002 The module SHALL have parameter CNT_W, default 16, meaning the width of the encoded-word counter.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port in_valid/in_ready, input/output, 1 bit each: field-bundle handshake.
REQ-006 The module SHALL have port in_fmt, input, 3 bits: format, fmt_t.
REQ-007 The module SHALL have ports in_opcode (7 bits), in_rd/in_rs1/in_rs2 (5 bits each), in_funct3 (3 bits), in_funct7 (7 bits), all inputs.
REQ-008 The module SHALL have port in_imm, input, 32 bits: signed immediate, byte offset for B/J.
REQ-009 The module SHALL have port in_last, input, 1 bit: marks the final instruction of a program.
REQ-010 The module SHALL have ports out_valid/out_ready, output/input, 1 bit each: encoded-word handshake.
REQ-011 The module SHALL have port out_instr, output, 32 bits: encoded RV32I word.
REQ-012 The module SHALL have port out_addr, output, 32 bits: memory address of out_instr.
REQ-013 The module SHALL have port out_err, output, 1 bit: the current word had an illegal format or an illegal field.
REQ-014 The module SHALL have port done, output, 1 bit: one-cycle pulse after the last word transfers.
REQ-015 The module SHALL have port word_cnt, output, CNT_W bits: words emitted in the current program.
REQ-016 The module SHALL have port err_sticky, output, 1 bit: any out_err since reset or since the last done.

Function
REQ-017 A transfer SHALL occur on each side when valid and ready are both high at a rising clk edge.
REQ-018 The block SHALL use a single output register stage with in_ready = !out_valid || out_ready, giving full throughput and 1-cycle latency.
REQ-019 out_valid and all out_* outputs SHALL remain stable while out_valid && !out_ready.
REQ-020 Packing SHALL follow RV32I: R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
REQ-021 Packing SHALL follow RV32I: B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-022 Shift-immediates SHALL be given as I format, with in_imm[11:5] carrying funct7 and in_imm[4:0] carrying shamt.
REQ-023 fmt values 6 and 7 SHALL emit 32'h0000_0013 (NOP) with out_err=1, in every configuration.
REQ-024 The FSM SHALL have states IDLE, RUN, and DONE.
REQ-025 IDLE SHALL move to RUN on the first input transfer.
REQ-026 RUN SHALL move to DONE on the output transfer of a word tagged last.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-028 out_addr SHALL be BASE_ADDR for the first word and +4 per output transfer, wrapping modulo 2^32.
REQ-029 In DONE, the address SHALL reload to BASE_ADDR and word_cnt SHALL clear to 0.
REQ-030 word_cnt SHALL increment per output transfer and saturate at all-ones.
REQ-031 An input transfer SHALL be accepted in DONE, and that word SHALL begin the next program at BASE_ADDR.
REQ-032 A simultaneous output transfer and input transfer SHALL both complete in the same cycle.

Reset
REQ-033 When rst=1 at a clk edge, the FSM SHALL go to IDLE.
REQ-034 Reset SHALL set out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, done=0, word_cnt=0, err_sticky=0, and in_ready=1 in the next cycle.
REQ-035 Reset mid-program SHALL discard the held word without emitting it.

Configuration
REQ-036 With IMM_CHECK_EN defined, out_err SHALL also assert for: I/S imm outside [-2048,2047]; B imm outside [-4096,4094] or odd; J imm outside [-2^20,2^20-2] or odd; U imm[11:0]!=0.
REQ-037 Under IMM_CHECK_EN, a word failing the check SHALL still be emitted with the bits truncated per REQ-020/REQ-021.
REQ-038 With IMM_CHECK_EN undefined, no range/alignment logic SHALL exist, and out_err SHALL reflect the fmt check only.

Structure
REQ-039 Package instr_pkg SHALL hold fmt_t (R=0,I=1,S=2,B=3,U=4,J=5), the RV32I opcode constants, and NOP_INSTR.
REQ-040 Combinational packing SHALL be the sub-module instr_pack (fields in, 32-bit word and err out).
REQ-041 instr_encode SHALL hold only the FSM, the output register, and the counters.

Verification
REQ-042 The bench SHALL check I, rd=1, rs1=1, f3=0, op=0x13, imm=2 -> 32'h0020_8093 at out_addr 0x0.
REQ-043 The bench SHALL check back-to-back U(op 0x37, rd=1, imm=0x1000), R(op 0x33, rd=rs1=rs2=1), J(op 0x6F, rd=1, imm=16) -> 32'h0000_10B7, 32'h0010_80B3, 32'h0100_00EF at addresses 0x0/0x4/0x8, one per cycle.
REQ-044 The bench SHALL check B, rs1=rs2=1, f3=0, op=0x63, imm=8, in_last=1 -> 32'h0010_8463, then done pulses 1 cycle, word_cnt 1 -> 0, and the next word lands at BASE_ADDR.
REQ-045 The bench SHALL check out_ready=0 for 3 cycles with 2 words offered -> in_ready=0 and out_* stable, then both words drain in order with no loss.
REQ-046 The bench SHALL check in_fmt=7 -> 32'h0000_0013 with out_err=1 and err_sticky=1.
REQ-047 Under IMM_CHECK_EN, the bench SHALL check I imm=2048 and B imm=3 -> out_err=1.
REQ-048 The bench SHALL check rst asserted mid-program -> outputs per REQ-034 next cycle and the held word never appears.
